// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem read at a time,
// and drops the stale response left in flight by a redirect.
package if_stage_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } if_rvfi_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    if_rvfi_t    rvfi;
  } if_stage_t;
endpackage

module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_pc_target,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic        imem_resp,
  output logic        o_discard,
  output if_stage_t   if_stage_reg
);

  typedef enum logic [1:0] {
    S_START,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  if_stage_t   r_if_reg;

  logic        w_issue;
  logic        w_discard;
  logic [31:0] w_addr;
  logic [31:0] w_addr_next;
  logic [31:0] w_tgt_aligned;
  logic [31:0] w_pc_inc;

  assign w_tgt_aligned = {i_pc_target[31:2], 2'b00};
  assign w_pc_inc      = r_pc + 32'd4;
  assign w_addr_next   = w_addr + 32'd4;

  // Issue is decided combinationally so a returning response can be
  // followed by the next fetch in the very same cycle.
  always_comb begin
    w_issue   = 1'b0;
    w_discard = 1'b0;
    w_addr    = r_pc;
    if (!rst) begin
      case (r_state)
        S_START: begin
          w_issue   = 1'b1;
          w_discard = imem_resp;
          w_addr    = i_flush ? w_tgt_aligned : r_pc;
        end
        S_WAIT: begin
          if (imem_resp) begin
            if (i_flush) begin
              w_issue = 1'b1;
              w_addr  = w_tgt_aligned;
            end else if (!i_stall) begin
              w_issue = 1'b1;
              w_addr  = w_pc_inc;
            end
          end
        end
        S_HOLD: begin
          if (i_flush) begin
            w_issue = 1'b1;
            w_addr  = w_tgt_aligned;
          end else if (!i_stall) begin
            w_issue = 1'b1;
            w_addr  = w_pc_inc;
          end
        end
        S_DISCARD: begin
          if (imem_resp) begin
            w_discard = 1'b1;
            w_issue   = 1'b1;
            w_addr    = i_flush ? w_tgt_aligned : r_tgt;
          end
        end
        default: begin
          w_issue = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_START;
      r_pc     <= RESET_PC;
      r_tgt    <= '0;
      r_if_reg <= '0;
    end else if (w_issue) begin
      r_state                <= S_WAIT;
      r_pc                   <= w_addr;
      r_if_reg.pc            <= w_addr;
      r_if_reg.pc_next       <= w_addr_next;
      r_if_reg.rvfi.valid    <= 1'b1;
      r_if_reg.rvfi.pc_rdata <= w_addr;
      r_if_reg.rvfi.pc_wdata <= w_addr_next;
    end else begin
      case (r_state)
        S_WAIT: begin
          // A response without an issue here can only mean a stall.
          if (imem_resp) begin
            r_state <= S_HOLD;
          end else if (i_flush) begin
            r_state <= S_DISCARD;
            r_tgt   <= w_tgt_aligned;
          end
        end
        S_DISCARD: begin
          if (i_flush) begin
            r_tgt <= w_tgt_aligned;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign imem_addr    = w_addr;
  assign imem_rmask   = w_issue ? 4'hF : 4'h0;
  assign o_discard    = w_discard;
  assign if_stage_reg = r_if_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a flag-based fetch model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic [31:0] i_pc_target = '0;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_resp = 1'b0;
  logic        o_discard;
  if_stage_t   if_stage_reg;

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_pc_target (i_pc_target),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_resp   (imem_resp),
    .o_discard   (o_discard),
    .if_stage_reg(if_stage_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: whether a fetch is outstanding, whether a redirect is pending
  // against it, whether a delivered word is being held, or whether we are
  // fresh out of reset.
  logic        m_fresh = 1'b1;
  logic        m_out   = 1'b0;
  logic        m_pend  = 1'b0;
  logic        m_buf   = 1'b0;
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_ptgt  = '0;
  logic [31:0] m_rpc   = '0;
  logic [31:0] m_rnext = '0;
  logic        m_valid = 1'b0;

  always @(negedge clk) begin : compare
    logic        e_issue;
    logic        e_disc;
    logic [31:0] e_addr;
    logic [31:0] t;
    if (mon_en) begin
      t       = {i_pc_target[31:2], 2'b00};
      e_issue = 1'b0;
      e_disc  = 1'b0;
      e_addr  = '0;
      if (!rst) begin
        if (m_fresh) begin
          e_disc  = imem_resp;
          e_issue = 1'b1;
          e_addr  = i_flush ? t : m_pc;
        end else if (m_out && imem_resp) begin
          if (m_pend) begin
            e_disc  = 1'b1;
            e_issue = 1'b1;
            e_addr  = i_flush ? t : m_ptgt;
          end else if (i_flush) begin
            e_issue = 1'b1;
            e_addr  = t;
          end else if (!i_stall) begin
            e_issue = 1'b1;
            e_addr  = m_pc + 32'd4;
          end
        end else if (m_buf) begin
          if (i_flush) begin
            e_issue = 1'b1;
            e_addr  = t;
          end else if (!i_stall) begin
            e_issue = 1'b1;
            e_addr  = m_pc + 32'd4;
          end
        end
      end

      chk("rmask", {28'd0, imem_rmask}, e_issue ? 32'hF : 32'h0);
      chk("discard", {31'd0, o_discard}, {31'd0, e_disc});
      if (e_issue) begin
        chk("addr", imem_addr, e_addr);
        $display("issue addr=%h discard=%b", e_addr, e_disc);
      end
      chk("reg.pc", if_stage_reg.pc, m_rpc);
      chk("reg.pc_next", if_stage_reg.pc_next, m_rnext);
      chk("reg.valid", {31'd0, if_stage_reg.rvfi.valid}, {31'd0, m_valid});
      chk("reg.pc_rdata", if_stage_reg.rvfi.pc_rdata, m_rpc);
      chk("reg.pc_wdata", if_stage_reg.rvfi.pc_wdata, m_rnext);

      if (rst) begin
        m_fresh = 1'b1; m_out = 1'b0; m_pend = 1'b0; m_buf = 1'b0;
        m_pc = RST_PC; m_rpc = '0; m_rnext = '0; m_valid = 1'b0;
      end else if (e_issue) begin
        m_fresh = 1'b0; m_out = 1'b1; m_pend = 1'b0; m_buf = 1'b0;
        m_pc = e_addr; m_rpc = e_addr; m_rnext = e_addr + 32'd4; m_valid = 1'b1;
      end else if (m_out) begin
        if (imem_resp) begin
          m_out = 1'b0;
          m_buf = 1'b1;
        end else if (i_flush) begin
          m_pend = 1'b1;
          m_ptgt = t;
        end
      end
    end
  end

  task automatic go(input logic r, input logic s, input logic f,
                    input logic [31:0] t, input logic rs);
    @(posedge clk);
    #1;
    rst = r; i_stall = s; i_flush = f; i_pc_target = t; imem_resp = rs;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset release and back-to-back fetch, then a slow response.
    go(1, 0, 0, 0, 0);
    chk("lit rst rmask", {28'd0, imem_rmask}, 32'h0);
    chk("lit rst discard", {31'd0, o_discard}, 32'h0);
    chk("lit rst reg.pc", if_stage_reg.pc, 32'h0);
    go(0, 0, 0, 0, 0);
    chk("lit first addr", imem_addr, 32'h1eceb000);
    chk("lit first rmask", {28'd0, imem_rmask}, 32'hF);
    chk("lit first valid", {31'd0, if_stage_reg.rvfi.valid}, 32'h0);
    go(0, 0, 0, 0, 1);
    chk("lit b2b addr", imem_addr, 32'h1eceb004);
    chk("lit b2b reg.pc", if_stage_reg.pc, 32'h1eceb000);
    chk("lit b2b valid", {31'd0, if_stage_reg.rvfi.valid}, 32'h1);
    go(0, 0, 0, 0, 0);
    chk("lit wait rmask", {28'd0, imem_rmask}, 32'h0);
    chk("lit wait reg.pc", if_stage_reg.pc, 32'h1eceb004);
    go(0, 1, 0, 0, 0);
    chk("lit wait stall rmask", {28'd0, imem_rmask}, 32'h0);
    go(0, 0, 0, 0, 0);
    chk("lit wait addr held", imem_addr, 32'h1eceb004);
    go(0, 0, 0, 0, 1);
    chk("lit late resp addr", imem_addr, 32'h1eceb008);

    // Stall on response holds; release issues the next word.
    go(1, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 1);
    go(0, 1, 0, 0, 1);
    chk("lit hold rmask", {28'd0, imem_rmask}, 32'h0);
    go(0, 1, 0, 0, 0);
    chk("lit hold reg.pc", if_stage_reg.pc, 32'h1eceb004);
    go(0, 0, 0, 0, 0);
    chk("lit unstall addr", imem_addr, 32'h1eceb008);

    // Redirect together with a response.
    go(0, 0, 1, 32'h1eceb100, 1);
    chk("lit flush addr", imem_addr, 32'h1eceb100);
    chk("lit flush discard", {31'd0, o_discard}, 32'h0);
    go(0, 0, 0, 0, 0);
    chk("lit flush reg.pc", if_stage_reg.pc, 32'h1eceb100);
    chk("lit flush pc_next", if_stage_reg.pc_next, 32'h1eceb104);

    // Redirect while waiting: stale response dropped, newest target wins.
    go(0, 0, 1, 32'h1eceb202, 0);
    chk("lit disc rmask", {28'd0, imem_rmask}, 32'h0);
    go(0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 1);
    chk("lit disc flag", {31'd0, o_discard}, 32'h1);
    chk("lit disc addr", imem_addr, 32'h1eceb200);
    go(0, 0, 1, 32'h1eceb202, 0);
    go(0, 1, 1, 32'h1eceb300, 0);
    go(0, 0, 0, 0, 1);
    chk("lit disc2 addr", imem_addr, 32'h1eceb300);
    go(0, 0, 1, 32'h1eceb400, 0);
    go(0, 0, 1, 32'h1eceb500, 1);
    chk("lit disc3 addr", imem_addr, 32'h1eceb500);

    // Redirect out of HOLD, then an address wrap.
    go(0, 1, 0, 0, 1);
    go(0, 1, 1, 32'h1eceb600, 0);
    chk("lit hold flush addr", imem_addr, 32'h1eceb600);
    go(0, 0, 1, 32'hFFFFFFFD, 1);
    chk("lit wrap addr", imem_addr, 32'hFFFFFFFC);
    go(0, 0, 0, 0, 0);
    chk("lit wrap pc_next", if_stage_reg.pc_next, 32'h0);
    go(0, 0, 0, 0, 1);
    chk("lit wrap next addr", imem_addr, 32'h0);

    // Reset mid-request and a late response in START.
    go(1, 0, 0, 0, 1);
    chk("lit midrst rmask", {28'd0, imem_rmask}, 32'h0);
    chk("lit midrst discard", {31'd0, o_discard}, 32'h0);
    go(0, 0, 0, 0, 1);
    chk("lit start discard", {31'd0, o_discard}, 32'h1);
    chk("lit start addr", imem_addr, 32'h1eceb000);
    chk("lit start reg.pc", if_stage_reg.pc, 32'h0);
    go(0, 0, 0, 0, 1);
    chk("lit restart next", imem_addr, 32'h1eceb004);

    // Mixed traffic cross-checked against the model only.
    for (int i = 0; i < 300; i++) begin
      go(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0),
         ($urandom_range(0, 5) == 0), $urandom, $urandom_range(0, 1) == 1);
    end

    go(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction Fetch pipeline stage. Owns the architectural fetch PC and issues one word read per fetch on the instruction-memory port.
- Produces the IF pipeline register that the decode stage pairs with the returning imem data.
- Handles pipeline stalls, branch/jump redirects and the discard of a stale in-flight response after a redirect.
- Sits directly upstream of id_stage.

Parameters:
- RESET_PC, 32'h1eceb000, address of the first fetch after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- i_stall  input  1  pipeline stall (OR of id_stall, imem_stall, load_hazard, downstream stalls).
- i_flush  input  1  redirect request from EX; same signal that flushes id_stage.
- i_pc_target  input  32  redirect target, valid when i_flush=1.
- imem_addr  output  32  fetch address, meaningful when imem_rmask!=0.
- imem_rmask  output  4  4'hF for exactly one cycle per issued fetch, else 4'h0.
- imem_resp  input  1  one-cycle response for the oldest outstanding fetch.
- o_discard  output  1  high in the cycle a stale response is dropped; downstream treats imem_rdata as a bubble.
- if_stage_reg  output  if_stage_t  fields pc, pc_next, rvfi.valid, rvfi.pc_rdata, rvfi.pc_wdata.

Behaviour:
- Outstanding requests: at most one at a time. A fetch is "issued" in a cycle with imem_rmask=4'hF. Its response is the next imem_resp, one or more cycles later.
- Address alignment: all issued addresses have [1:0]=2'b00. i_pc_target[1:0] is ignored (forced 0).
- States: START, WAIT, HOLD, DISCARD.
  - Reset: state=START, pc_q=RESET_PC, imem_rmask=0, o_discard=0, all if_stage_reg fields=0.
- Issue action at address A, always in the same cycle as the triggering condition:
  - imem_addr=A, imem_rmask=4'hF, pc_q<=A.
  - if_stage_reg.pc<=A, pc_next<=A+4, rvfi.valid<=1, rvfi.pc_rdata<=A, rvfi.pc_wdata<=A+4 (32-bit wrap).
  - state<=WAIT.
- START: issue at pc_q on the first cycle after rst deasserts. If i_flush=1, issue at the target instead.
- WAIT:
  - imem_resp=1 and i_flush=1: issue at the target; the response is consumed by id_stage as a flushed NOP.
  - imem_resp=1, i_stall=0: issue at pc_q+4 (back-to-back, zero bubble).
  - imem_resp=1, i_stall=1: no issue; state<=HOLD.
  - imem_resp=0, i_flush=1: no issue; latch tgt_q<=target; state<=DISCARD.
  - imem_resp=0, i_flush=0: stay in WAIT. i_stall has no effect.
- HOLD (response delivered, decode buffering it):
  - i_flush=1: issue at the target.
  - i_stall=0: issue at pc_q+4.
  - Otherwise hold, with imem_rmask=0.
- DISCARD:
  - imem_resp=1: o_discard=1 and the response is dropped. Issue at tgt_q in the same cycle; if i_flush=1 that cycle, issue at i_pc_target instead.
  - imem_resp=0 and i_flush=1: tgt_q<=i_pc_target (newest redirect wins).
- Priority: rst > i_flush > i_stall.
- if_stage_reg holds its value in all cycles without an issue.
- rst asserted mid-request: return to START next cycle. Any response arriving while in START is ignored, and that cycle has o_discard=1.

Test Plan:
- Reset release, imem_resp every cycle after each 1-cycle latency: addresses 1eceb000, 1eceb004, 1eceb008 issued back-to-back; if_stage_reg.pc tracks each issue; rvfi.valid=1 from the first issue.
- imem_resp held 0 for 3 cycles after issue at 1eceb004: imem_rmask=0 for those cycles, imem_addr/if_stage_reg unchanged. Resp on cycle 4 gives issue of 1eceb008 in that cycle.
- Resp arrives with i_stall=1 for 2 cycles: state HOLD, no issue, if_stage_reg.pc stays 1eceb004. Stall drops: issue 1eceb008 the same cycle.
- i_flush with target 1eceb100 in the same cycle as resp: issue 1eceb100 immediately, o_discard=0, if_stage_reg.pc=1eceb100, pc_next=1eceb104.
- i_flush with target 1eceb202 while in WAIT with no resp: no issue. Next resp gives o_discard=1 and issue of 1eceb200 that cycle. A second flush with target 1eceb300 before the resp gives issue of 1eceb300 instead.
- rst pulsed while in WAIT: outputs zero; next cycle issue at 1eceb000. A late resp during START is dropped with o_discard=1.
